// File: rtl/data_ram_ws.sv
// Single-port data memory for the MEM stage: byte-lane writes, registered read,
// programmable wait states and out-of-range address detection.
module data_ram_ws #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int WAIT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                we,
  input  logic [DATA_W/8-1:0] sel,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                ack,
  output logic                busy,
  output logic                addr_err
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS   = $clog2(LANES);
  localparam int IDX   = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              we_p1;
  logic [LANES-1:0]  sel_p1;
  logic [IDX-1:0]    idx_p1;
  logic              err_p1;
  logic [DATA_W-1:0] data_p1;

  logic [IDX-1:0]    in_idx;
  logic              in_err;
  logic              unused_addr;

  logic              req_we;
  logic [LANES-1:0]  req_sel;
  logic [IDX-1:0]    req_idx;
  logic              req_err;
  logic [DATA_W-1:0] req_data;
  logic              accept;
  logic              commit;

  function automatic logic [DATA_W-1:0] lane_mask(input logic [DATA_W-1:0] w,
                                                  input logic [LANES-1:0]  s);
    for (int i = 0; i < LANES; i++)
      lane_mask[8*i +: 8] = s[i] ? w[8*i +: 8] : 8'h00;
  endfunction

  assign in_idx      = addr[OFS+IDX-1:OFS];
  assign in_err      = |(addr >> (OFS + IDX));
  assign unused_addr = ^addr;

  assign accept = (state == S_IDLE) && ce;

  // With WAIT=0 the commit edge is also the accept edge, so the live inputs
  // stand in for the not-yet-latched request.
  assign req_we   = (state == S_IDLE) ? we     : we_p1;
  assign req_sel  = (state == S_IDLE) ? sel    : sel_p1;
  assign req_idx  = (state == S_IDLE) ? in_idx : idx_p1;
  assign req_err  = (state == S_IDLE) ? in_err : err_p1;
  assign req_data = (state == S_IDLE) ? data_i : data_p1;

  assign commit = rst && (state_nxt == S_RESP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (ce) begin
          cnt_nxt   = 3'(WAIT);
          state_nxt = (WAIT > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt <= 3'd1)
          state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: control state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      addr_err <= 1'b0;
      data_o   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= (state_nxt == S_RESP);
      busy  <= (state_nxt != S_IDLE);
      if (state_nxt == S_RESP) begin
        addr_err <= req_err;
        data_o   <= (req_we || req_err) ? '0 : lane_mask(mem[req_idx], req_sel);
      end else begin
        addr_err <= 1'b0;
        data_o   <= '0;
      end
    end
  end

  // Stage p1: request captured at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p1   <= we;
      sel_p1  <= sel;
      idx_p1  <= in_idx;
      err_p1  <= in_err;
      data_p1 <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && req_we && !req_err) begin
      for (int i = 0; i < LANES; i++)
        if (req_sel[i])
          mem[req_idx][8*i +: 8] <= req_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_ram_ws.sv
// Self-checking bench for data_ram_ws: three instances (WAIT = 0, 1, 3) driven
// from one directed/randomized sequence and compared to a word-array model.
module tb_data_ram_ws;

  localparam int NU = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce   [NU];
  logic        we   [NU];
  logic [3:0]  sel  [NU];
  logic [31:0] addr [NU];
  logic [31:0] din  [NU];
  logic [31:0] dout [NU];
  logic        ack  [NU];
  logic        busy [NU];
  logic        err  [NU];

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mdl [NU][1024];

  data_ram_ws #(.WAIT(0)) u0 (.clk(clk), .rst(rst), .ce(ce[0]), .we(we[0]), .sel(sel[0]),
    .addr(addr[0]), .data_i(din[0]), .data_o(dout[0]), .ack(ack[0]), .busy(busy[0]),
    .addr_err(err[0]));
  data_ram_ws #(.WAIT(1)) u1 (.clk(clk), .rst(rst), .ce(ce[1]), .we(we[1]), .sel(sel[1]),
    .addr(addr[1]), .data_i(din[1]), .data_o(dout[1]), .ack(ack[1]), .busy(busy[1]),
    .addr_err(err[1]));
  data_ram_ws #(.WAIT(3)) u2 (.clk(clk), .rst(rst), .ce(ce[2]), .we(we[2]), .sel(sel[2]),
    .addr(addr[2]), .data_i(din[2]), .data_o(dout[2]), .ack(ack[2]), .busy(busy[2]),
    .addr_err(err[2]));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  function automatic int wt(input int u);
    return (u == 0) ? 0 : (u == 1) ? 1 : 3;
  endfunction

  function automatic logic out_of_range(input logic [31:0] a);
    return a[31:12] != 20'h0;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? w[8*i +: 8] : 8'h00;
    return r;
  endfunction

  task automatic chk(input int u, input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL u%0d %s: observed %h expected %h", u, tag, obs, exp);
    end
  endtask

  // One request on unit u, starting and ending at a negedge with the unit idle.
  task automatic txn(input int u, input bit wr, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] q);
    int          w;
    logic        exp_e;
    logic [31:0] exp_q;
    w     = wt(u);
    exp_e = out_of_range(a);
    exp_q = (wr || exp_e) ? 32'h0 : lanes(mdl[u][a[11:2]], s);
    chk(u, "pre_busy", busy[u], 0);
    ce[u] = 1'b1; we[u] = wr; sel[u] = s; addr[u] = a; din[u] = d;
    @(posedge clk);
    @(negedge clk);
    ce[u] = 1'b0; we[u] = 1'($urandom); sel[u] = 4'($urandom);
    addr[u] = $urandom; din[u] = $urandom;
    for (int k = 1; k <= w + 1; k++) begin
      if (k > 1) @(negedge clk);
      chk(u, "busy", busy[u], 1);
      chk(u, "ack", ack[u], 32'(k == w + 1));
    end
    q = dout[u];
    chk(u, "data_o", dout[u], exp_q);
    chk(u, "addr_err", err[u], exp_e);
    if (wr && !exp_e)
      for (int i = 0; i < 4; i++)
        if (s[i]) mdl[u][a[11:2]][8*i +: 8] = d[8*i +: 8];
    @(negedge clk);
    chk(u, "idle_busy", busy[u], 0);
    chk(u, "idle_ack", ack[u], 0);
  endtask

  initial begin
    logic [31:0] q;
    logic [31:0] a;
    logic [31:0] acc_addr [$];

    for (int u = 0; u < NU; u++) begin
      ce[u] = 1'b1; we[u] = 1'b1; sel[u] = 4'hF;
      addr[u] = 32'h40; din[u] = $urandom;
    end

    // Reset held 3 cycles with ce high
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
        chk(u, "rst_ack", ack[u], 0);
        chk(u, "rst_busy", busy[u], 0);
        chk(u, "rst_err", err[u], 0);
        chk(u, "rst_data", dout[u], 0);
      end
    end
    ce[0] = 1'b0; ce[2] = 1'b0;
    rst = 1'b1;

    // First accept right after release, then read-after-write
    txn(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, q);
    txn(1, 1'b0, 4'hF, 32'h10, 32'h0, q);
    chk(1, "raw_const", q, 32'hDEADBEEF);

    // Byte lanes
    txn(1, 1'b1, 4'hF, 32'h40, 32'hAAAAAAAA, q);
    txn(1, 1'b1, 4'b0101, 32'h40, 32'h11223344, q);
    txn(1, 1'b0, 4'hF, 32'h40, 32'h0, q);
    chk(1, "lane_full", q, 32'hAA22AA44);
    txn(1, 1'b0, 4'b1100, 32'h40, 32'h0, q);
    chk(1, "lane_hi", q, 32'hAA220000);

    // Out of range: read and write at 0x1000 must not touch word 0
    txn(1, 1'b1, 4'hF, 32'h0, 32'h5A5A5A5A, q);
    txn(1, 1'b0, 4'hF, 32'h1000, 32'h0, q);
    txn(1, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, q);
    txn(1, 1'b0, 4'hF, 32'h0, 32'h0, q);
    chk(1, "oor_keep", q, 32'h5A5A5A5A);

    // Back-to-back with ce held high and inputs changing every cycle (WAIT=3)
    for (int e = 0; e < 20; e++) begin
      ce[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF;
      addr[2] = 32'h100 + 32'(4 * $urandom_range(0, 15));
      din[2] = $urandom;
      @(posedge clk);
      if (e % 5 == 0) begin
        mdl[2][addr[2][11:2]] = din[2];
        acc_addr.push_back(addr[2]);
      end
      @(negedge clk);
      chk(2, "b2b_ack", ack[2], 32'(e % 5 == 3));
      chk(2, "b2b_busy", busy[2], 32'(e % 5 != 4));
    end
    ce[2] = 1'b0;
    foreach (acc_addr[i]) txn(2, 1'b0, 4'hF, acc_addr[i], 32'h0, q);

    // Reset two cycles into a WAIT=3 write
    txn(2, 1'b1, 4'hF, 32'h0, 32'h0, q);
    ce[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; addr[2] = 32'h0; din[2] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    ce[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk(2, "midrst_ack", ack[2], 0);
      chk(2, "midrst_busy", busy[2], 0);
      @(negedge clk);
    end
    txn(2, 1'b0, 4'hF, 32'h0, 32'h0, q);
    chk(2, "midrst_data", q, 32'h0);

    // Randomized traffic on every unit over a small window of words
    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < 16; i++)
        txn(u, 1'b1, 4'hF, 32'h200 + 32'(4 * i), $urandom, q);
      for (int t = 0; t < 30; t++) begin
        a = 32'h200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
        txn(u, 1'($urandom), 4'($urandom), a, $urandom, q);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_ram_ws.md
# data_ram_ws

Parametrised single-port data memory for the MEM stage. It adds byte-lane write enables, a synchronous registered read, a programmable number of wait states, and out-of-range address detection. It sits behind the MEM-stage load/store path and replaces the fixed 32-bit combinational-read RAM. The MEM stage issues one request, holds off while `busy` is high, and consumes the result on the single-cycle `ack`.

## Interface
- `DATA_W`, 32: data width in bits; a multiple of 8.
- `DEPTH`, 1024: number of words; a power of two.
- `ADDR_W`, 32: width of the byte address.
- `WAIT`, 1: extra wait cycles per access; range 0..7.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `ce` input 1: request strobe; sampled only in IDLE.
- `we` input 1: 1 = write, 0 = read.
- `sel` input DATA_W/8: byte-lane enables; bit i covers `data[8i+7:8i]`.
- `addr` input ADDR_W: byte address.
- `data_i` input DATA_W: write data.
- `data_o` output DATA_W: read data; valid only while `ack` is high.
- `ack` output 1: one-cycle completion pulse.
- `busy` output 1: high while a request is in flight; `ce` is ignored while it is high.
- `addr_err` output 1: out-of-range flag; qualified by `ack`.

## Operation
- Definitions:
  - OFS = log2(DATA_W/8).
  - IDX = log2(DEPTH).
  - Word index = `addr[OFS+IDX-1:OFS]`.
  - Low OFS bits are ignored; alignment is the MEM stage's responsibility.
- Out of range: any set bit in `addr[ADDR_W-1:OFS+IDX]`.
  - Memory is not accessed.
  - `addr_err`=1 with `ack`.
  - `data_o`=0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE & `ce`=1 → accept. Latch `we`, `sel`, `addr`, `data_i`, and load the wait counter with WAIT. Next state is WAIT if WAIT>0, else RESP.
  - IDLE & `ce`=0 → stay in IDLE.
  - WAIT → decrement the counter each cycle. When the counter reaches 1, go to RESP (WAIT cycles in total).
  - RESP → one cycle, then IDLE.
- The memory access happens on the edge that enters RESP, using the latched request only.
  - Write: for each lane i with `sel[i]`=1, `mem[idx]` lane i ← latched `data_i` lane i. Other lanes are unchanged.
  - Read: `data_o` lane i ← `mem[idx]` lane i if `sel[i]`=1, else 0.
  - Write acknowledgement: `data_o`=0.
- `sel`=0: no memory change; read returns 0; `ack` still pulses.
- Changes to request inputs after acceptance have no effect.
- The memory array is not reset; its contents are undefined until written.

## Timing
- Reset (`rst`=0 at an edge):
  - FSM → IDLE; `ack`=0, `busy`=0, `addr_err`=0, `data_o`=0.
  - The wait counter is cleared.
- Reset mid-operation: the in-flight request is dropped.
  - Its write is discarded if RESP has not yet been entered.
  - No `ack` is issued.
- Request accepted in cycle N:
  - `busy`=1 in cycles N+1 .. N+WAIT+1.
  - `ack`=1, with `data_o`/`addr_err` valid, in cycle N+WAIT+1 only.
- Latency = WAIT+1 cycles.
- The earliest next accept is cycle N+WAIT+2, when `ce` is sampled in IDLE. Throughput is one access per WAIT+2 cycles.
- `busy` is 0 in the accept cycle itself; `ce` held high continuously yields back-to-back requests at that throughput.
- `ack`, `busy`, `data_o`, and `addr_err` are all registered. There is no combinational path from inputs to outputs.
- Read after write to the same word: the second access observes the written data, because the write committed at the prior RESP edge.

## Test plan
- Reset: hold `rst`=0 for 3 cycles while `ce`=1.
  - Required: `ack`, `busy`, `addr_err`, `data_o` all 0.
  - After release, the first accept takes place in the first IDLE cycle.
- WAIT=1: write 0xDEADBEEF, `sel`=4'hF to `addr` 0x10, then read 0x10 with `sel`=4'hF.
  - Required: each `ack` 2 cycles after accept; the read returns 0xDEADBEEF.
- Byte lanes: write 0x11223344 with `sel`=4'b0101 over a word holding 0xAAAAAAAA.
  - Required: read with `sel`=4'hF returns 0xAA22AA44.
  - Required: read with `sel`=4'b1100 returns 0xAA220000.
- Out of range (DEPTH=1024): read at `addr` 0x1000.
  - Required: `ack`=1, `addr_err`=1, `data_o`=0, and memory unchanged.
- Handshake: `ce` held high, `data_i` changing every cycle, WAIT=3.
  - Required: accepts are spaced 5 cycles apart; each write stores the `data_i` value present at its accept cycle.
- Reset mid-write: accept a write of 0x12345678 with WAIT=3 over 0x0, then assert `rst` 2 cycles later.
  - Required: no `ack`; a subsequent read returns 0x0.
